// File: rtl/pid_move_ctrl.sv
// rtl/pid_move_ctrl.sv - move sequencer feeding heading error and forward speed to the PID
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cmd_vld/hdg/sqrs   move command (accepted only while idle)
//   hdg_vld, actl_hdg  heading sample strobe and measured heading
//   sqr_tick           one pulse per square boundary crossed
//   busy               high whenever a move is in progress
//   moving             PID enable
//   err_vld, error     registered error strobe and signed heading error
//   frwrd              forward speed operand
//   mv_done            one-cycle completion pulse
module pid_move_ctrl #(
    parameter logic [9:0]  FRWRD_MAX  = 10'h2A0,
    parameter logic [9:0]  FRWRD_INC  = 10'h018,
    parameter logic [9:0]  FRWRD_DEC  = 10'h030,
    parameter logic [11:0] HDG_TOL    = 12'h02C,
    parameter int          SETTLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    input  logic [11:0] cmd_hdg,
    input  logic [3:0]  cmd_sqrs,
    input  logic        hdg_vld,
    input  logic [11:0] actl_hdg,
    input  logic        sqr_tick,
    output logic        busy,
    output logic        moving,
    output logic        err_vld,
    output logic [11:0] error,
    output logic [9:0]  frwrd,
    output logic        mv_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        RAMP_UP = 3'd2,
        CRUISE  = 3'd3,
        RAMP_DN = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CNT);

    state_t      state_q, state_d;
    logic [11:0] dsrd_hdg_q, dsrd_hdg_d;
    logic [3:0]  sqr_goal_q, sqr_goal_d;
    logic [3:0]  sqr_cnt_q, sqr_cnt_d;
    logic [3:0]  settle_q, settle_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic [11:0] error_q, error_d;
    logic        err_vld_q, err_vld_d;

    logic [11:0] err_raw;
    logic [11:0] err_mag;
    logic        in_win;
    logic [10:0] frwrd_sum;
    logic        moving_d;

    always_comb begin
        state_d    = state_q;
        dsrd_hdg_d = dsrd_hdg_q;
        sqr_goal_d = sqr_goal_q;
        sqr_cnt_d  = sqr_cnt_q;
        settle_d   = settle_q;
        frwrd_d    = frwrd_q;
        error_d    = error_q;
        err_vld_d  = 1'b0;

        // Window test uses the heading latched for the current move.
        err_raw = actl_hdg - dsrd_hdg_q;
        if (err_raw[11]) begin
            // -2048 has no positive counterpart in 12 bits; clamp to 2047.
            err_mag = (err_raw == 12'h800) ? 12'h7FF : (12'h000 - err_raw);
        end else begin
            err_mag = err_raw;
        end
        in_win    = (err_mag < HDG_TOL);
        frwrd_sum = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};

        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    state_d    = TURN;
                    dsrd_hdg_d = cmd_hdg;
                    sqr_goal_d = cmd_sqrs;
                    sqr_cnt_d  = 4'd0;
                    settle_d   = 4'd0;
                    frwrd_d    = 10'd0;
                end
            end
            TURN: begin
                frwrd_d = 10'd0;
                if (settle_q == SETTLE_MAX) begin
                    state_d = (sqr_goal_q == 4'd0) ? DONE : RAMP_UP;
                end else if (hdg_vld) begin
                    settle_d = in_win ? (settle_q + 4'd1) : 4'd0;
                end
            end
            RAMP_UP: begin
                if (hdg_vld) begin
                    frwrd_d = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[9:0];
                end
                // Reaching the square goal wins over reaching cruise speed.
                if (sqr_cnt_q == sqr_goal_q) begin
                    state_d = RAMP_DN;
                end else if (frwrd_q == FRWRD_MAX) begin
                    state_d = CRUISE;
                end
            end
            CRUISE: begin
                if (sqr_cnt_q == sqr_goal_q) begin
                    state_d = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (hdg_vld) begin
                    frwrd_d = (frwrd_q < FRWRD_DEC) ? 10'd0 : (frwrd_q - FRWRD_DEC);
                end
                if (frwrd_q == 10'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Squares only count while actually driving forward.
        if (((state_q == RAMP_UP) || (state_q == CRUISE)) && sqr_tick && (sqr_cnt_q != 4'hF)) begin
            sqr_cnt_d = sqr_cnt_q + 4'd1;
        end

        moving_d = (state_d == TURN) || (state_d == RAMP_UP) ||
                   (state_d == CRUISE) || (state_d == RAMP_DN);

        // Error is published against the heading in force after this edge.
        err_vld_d = hdg_vld && moving_d;
        if (err_vld_d) begin
            error_d = actl_hdg - dsrd_hdg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dsrd_hdg_q <= 12'd0;
            sqr_goal_q <= 4'd0;
            sqr_cnt_q  <= 4'd0;
            settle_q   <= 4'd0;
            frwrd_q    <= 10'd0;
            error_q    <= 12'd0;
            err_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dsrd_hdg_q <= dsrd_hdg_d;
            sqr_goal_q <= sqr_goal_d;
            sqr_cnt_q  <= sqr_cnt_d;
            settle_q   <= settle_d;
            frwrd_q    <= frwrd_d;
            error_q    <= error_d;
            err_vld_q  <= err_vld_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign moving  = (state_q == TURN) || (state_q == RAMP_UP) ||
                     (state_q == CRUISE) || (state_q == RAMP_DN);
    assign mv_done = (state_q == DONE);
    assign err_vld = err_vld_q;
    assign error   = error_q;
    assign frwrd   = frwrd_q;

endmodule
